data_mem_lsu: RTL



---
 rtl/dmem_pkg.sv | 10 +
 rtl/dmem_lane_fmt.sv | 35 +++
 rtl/data_mem_lsu.sv | 76 +++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared funct3 codes, FSM states and lane width for data_mem_lsu.
package dmem_pkg;
  localparam int BE_W = 4;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic {CLEAR, IDLE} state_t;
endpackage

// File: rtl/dmem_lane_fmt.sv
// dmem_lane_fmt: byte enables, store-lane shift, load extension and error decode.
module dmem_lane_fmt
  import dmem_pkg::*;
(
  input  logic            we,
  input  logic [2:0]      funct3,
  input  logic [1:0]      off,
  input  logic [31:0]     rword,
  input  logic [31:0]     wdata,
  output logic [BE_W-1:0] be,
  output logic [31:0]     wshift,
  output logic [31:0]     rdata,
  output logic            err
);
  logic is_h, is_w, illegal;
  logic [31:0] rshift;
  logic [15:0] h16;
  logic [7:0] b8;
  always_comb begin
    is_h    = funct3 == F3_H || funct3 == F3_HU;
    is_w    = funct3 == F3_W;
    illegal = we ? funct3 > F3_W : (funct3 == 3'b011 || funct3[2:1] == 2'b11);
    err     = illegal || (is_h && off[0]) || (is_w && off != 2'b00);
    be      = err ? '0 : is_w ? 4'b1111 : is_h ? 4'b0011 << off : 4'b0001 << off;
    wshift  = wdata << {off, 3'b000};
    rshift  = rword >> {off, 3'b000};
    h16     = rshift[15:0];
    b8      = rshift[7:0];
    // funct3[2] selects the unsigned (zero-extending) load variants
    rdata   = err  ? '0 :
              is_w ? rword :
              is_h ? {{16{~funct3[2] & h16[15]}}, h16} :
                     {{24{~funct3[2] & b8[7]}}, b8};
  end
endmodule

// File: rtl/data_mem_lsu.sv
// data_mem_lsu: byte-addressable data memory with RV32I load/store unit and 1-cycle response.
// Define DMEM_CLEAR_ON_RESET_EN to zero the array one word per cycle after reset.
module data_mem_lsu
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic              REQ_WE,
  input  logic [2:0]        REQ_FUNCT3,
  input  logic [ADDR_W-1:0] REQ_ADDR,
  input  logic [31:0]       REQ_WDATA,
  output logic              RSP_VALID,
  output logic [31:0]       RSP_RDATA,
  output logic              RSP_ERR
);
  localparam int DEPTH_WORDS = 2**(ADDR_W-2);
  logic [31:0] mem [DEPTH_WORDS];
  logic [ADDR_W-3:0] idx;
  logic fire, err;
  logic [BE_W-1:0] be;
  logic [31:0] wshift, rdata;
  state_t state;
  assign idx  = REQ_ADDR[ADDR_W-1:2];
  assign fire = REQ_VALID && REQ_READY;
  dmem_lane_fmt u_fmt (
    .we     (REQ_WE),
    .funct3 (REQ_FUNCT3),
    .off    (REQ_ADDR[1:0]),
    .rword  (mem[idx]),
    .wdata  (REQ_WDATA),
    .be     (be),
    .wshift (wshift),
    .rdata  (rdata),
    .err    (err)
  );
`ifdef DMEM_CLEAR_ON_RESET_EN
  state_t state_nx;
  logic [ADDR_W-3:0] clr_cnt;
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nx;
      clr_cnt <= state == CLEAR ? clr_cnt + 1'b1 : clr_cnt;
    end
  end
  always_comb state_nx = (state == CLEAR && clr_cnt == (ADDR_W-2)'(DEPTH_WORDS-1)) ? IDLE : state;
`else
  assign state = IDLE;
`endif
  always_comb REQ_READY = state == IDLE && !RST;
  // requests are only accepted in IDLE, so clearing and stores never collide
  always_ff @(posedge CLK) begin
`ifdef DMEM_CLEAR_ON_RESET_EN
    if (!RST && state == CLEAR) mem[clr_cnt] <= '0;
`endif
    for (int i = 0; i < BE_W; i++)
      if (fire && REQ_WE && be[i]) mem[idx][8*i +: 8] <= wshift[8*i +: 8];
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      RSP_VALID <= 1'b0;
      RSP_RDATA <= '0;
      RSP_ERR   <= 1'b0;
    end else begin
      RSP_VALID <= fire;
      RSP_RDATA <= fire && !REQ_WE ? rdata : '0;
      RSP_ERR   <= fire && err;
    end
  end
endmodule
